// File: rtl/contador_modulo_n.sv
// ----------------------------------------------------------------------------
// contador_modulo_n
//
// Modulo-N up/down counter with a small run-control FSM (IDLE / RUN / DONE).
// Built to be cascaded as a decade-style digit: tc of a lower digit drives
// en of the next one. In timer mode (STOP_AT_ZERO=1) a down-count halts at 0
// and the FSM parks in DONE until reloaded or restarted.
//
// Parameters
//   WIDTH        counter width in bits
//   MODULUS      count range 0..MODULUS-1 (2..2^WIDTH)
//   RESET_VAL    q value while reset is asserted (0..MODULUS-1)
//   STOP_AT_ZERO 1 = down-count halts at 0 (timer), 0 = down-count wraps
//
// Ports
//   clk1      in   clock, all state changes on its rising edge
//   reset     in   asynchronous, active-low reset
//   en        in   count enable (cascade input from lower digit's tc)
//   up        in   direction: 1 = increment, 0 = decrement
//   start     in   run request
//   stop      in   pause request (wins over start)
//   load      in   synchronous parallel load (wins over counting)
//   load_val  in   value written on load, saturated to MODULUS-1
//   q         out  registered count
//   tc        out  combinational terminal count (carry/borrow out)
//   zero      out  combinational, high when q == 0
//   done      out  registered, high while the FSM is in DONE
// ----------------------------------------------------------------------------
module contador_modulo_n #(
    parameter int WIDTH        = 4,
    parameter int MODULUS      = 10,
    parameter int RESET_VAL    = 0,
    parameter int STOP_AT_ZERO = 1
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero,
    output logic             done
);

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_RESET = WIDTH'(RESET_VAL);
    localparam logic             TIMER   = (STOP_AT_ZERO != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q_next;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             halt;

    // Loads above the top of the range are clamped so q never leaves it.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v);
        return (v > Q_MAX) ? Q_MAX : v;
    endfunction

    assign at_max  = (q == Q_MAX);
    assign at_zero = (q == '0);

    // A qualifying count edge: running, enabled, and not overridden by load.
    assign step = (state == RUN) && en && !load;

    // Timer mode reaching the bottom: hold at 0 and finish instead of wrapping.
    assign halt = step && !up && at_zero && TIMER;

    // State register; done is registered from the next state so it tracks
    // DONE exactly without a combinational path from the inputs.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
        end
    end

    // Next-state logic, highest priority first.
    always_comb begin
        state_next = state;
        if (load && (state == DONE)) begin
            state_next = IDLE;
        end else if (stop && (state == RUN)) begin
            state_next = IDLE;
        end else if (start && ((state == IDLE) || (state == DONE))) begin
            state_next = RUN;
        end else if (halt) begin
            state_next = DONE;
        end
    end

    // Outputs. A halting timer digit must not borrow from its neighbour,
    // so the down-direction terminal count only exists in wrap mode.
    always_comb begin
        tc   = step && (up ? at_max : (at_zero && !TIMER));
        zero = at_zero;
    end

    // Count datapath.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = saturate(load_val);
        end else if (step) begin
            if (up) begin
                q_next = at_max ? '0 : q + WIDTH'(1);
            end else if (!at_zero) begin
                q_next = q - WIDTH'(1);
            end else if (!TIMER) begin
                q_next = Q_MAX;
            end
        end
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            q <= Q_RESET;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_contador_modulo_n.sv
// ----------------------------------------------------------------------------
// tb_contador_modulo_n
//
// Bench for contador_modulo_n. Two stand-alone instances share one stimulus
// bus: dut_a with defaults (mod 10, timer mode) and dut_b (mod 6, wrapping,
// reset value 3). A two-digit cascade (units mod 10, tens mod 6) is exercised
// separately. Each stand-alone instance is tracked by a behavioural model
// that keeps the count as a plain integer plus run/finished flags.
// ----------------------------------------------------------------------------
module tb_contador_modulo_n;

    localparam int MOD_A = 10;
    localparam int MOD_B = 6;
    localparam int RV_A  = 0;
    localparam int RV_B  = 3;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Shared stimulus for dut_a / dut_b
    logic       reset;
    logic       en;
    logic       up;
    logic       start;
    logic       stop;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] a_q;
    logic       a_tc;
    logic       a_zero;
    logic       a_done;
    logic [3:0] b_q;
    logic       b_tc;
    logic       b_zero;
    logic       b_done;

    // Cascade stimulus and outputs
    logic       c_en;
    logic       c_up;
    logic       c_start;
    logic       c_stop;
    logic       c_load;
    logic [3:0] c_lv_u;
    logic [3:0] c_lv_t;
    logic [3:0] u_q;
    logic       u_tc;
    logic       u_zero;
    logic       u_done;
    logic [3:0] t_q;
    logic       t_tc;
    logic       t_zero;
    logic       t_done;

    contador_modulo_n dut_a (
        .clk1(clk1), .reset(reset), .en(en), .up(up), .start(start),
        .stop(stop), .load(load), .load_val(load_val),
        .q(a_q), .tc(a_tc), .zero(a_zero), .done(a_done)
    );

    contador_modulo_n #(.WIDTH(4), .MODULUS(MOD_B), .RESET_VAL(RV_B), .STOP_AT_ZERO(0)) dut_b (
        .clk1(clk1), .reset(reset), .en(en), .up(up), .start(start),
        .stop(stop), .load(load), .load_val(load_val),
        .q(b_q), .tc(b_tc), .zero(b_zero), .done(b_done)
    );

    contador_modulo_n u_units (
        .clk1(clk1), .reset(reset), .en(c_en), .up(c_up), .start(c_start),
        .stop(c_stop), .load(c_load), .load_val(c_lv_u),
        .q(u_q), .tc(u_tc), .zero(u_zero), .done(u_done)
    );

    contador_modulo_n #(.WIDTH(4), .MODULUS(6)) u_tens (
        .clk1(clk1), .reset(reset), .en(u_tc), .up(c_up), .start(c_start),
        .stop(c_stop), .load(c_load), .load_val(c_lv_t),
        .q(t_q), .tc(t_tc), .zero(t_zero), .done(t_done)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int q;
        bit running;
        bit finished;
    } model_t;

    model_t ma;
    model_t mb;
    logic   last_tc_b;

    function automatic model_t model_step(model_t m, int modulus, bit timer,
                                          bit en_i, bit up_i, bit start_i,
                                          bit stop_i, bit load_i, int lv);
        model_t n = m;
        bit counting = m.running && en_i && !load_i;
        bool_dummy: begin end
        if (load_i)
            n.q = (lv >= modulus) ? modulus - 1 : lv;
        else if (counting) begin
            if (up_i)
                n.q = (m.q + 1) % modulus;
            else if (m.q > 0)
                n.q = m.q - 1;
            else
                n.q = timer ? 0 : (m.q - 1 + modulus) % modulus;
        end
        if (m.finished && load_i) begin
            n.running  = 1'b0;
            n.finished = 1'b0;
        end else if (m.running && stop_i) begin
            n.running = 1'b0;
        end else if (!m.running && start_i) begin
            n.running  = 1'b1;
            n.finished = 1'b0;
        end else if (counting && !up_i && m.q == 0 && timer) begin
            n.running  = 1'b0;
            n.finished = 1'b1;
        end
        return n;
    endfunction

    function automatic int model_tc(model_t m, int modulus, bit timer,
                                    bit en_i, bit up_i, bit load_i);
        if (!m.running || !en_i || load_i) return 0;
        if (up_i) return (m.q == modulus - 1) ? 1 : 0;
        return (m.q == 0 && !timer) ? 1 : 0;
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance models at
    // posedge, return at posedge+1.
    task automatic tick(input bit en_i, input bit up_i, input bit start_i,
                        input bit stop_i, input bit load_i, input int lv);
        en       = en_i;
        up       = up_i;
        start    = start_i;
        stop     = stop_i;
        load     = load_i;
        load_val = 4'(lv);
        @(negedge clk1);
        check_val("a_q",    int'(a_q),    ma.q);
        check_val("a_tc",   int'(a_tc),   model_tc(ma, MOD_A, 1'b1, en_i, up_i, load_i));
        check_val("a_zero", int'(a_zero), (ma.q == 0) ? 1 : 0);
        check_val("a_done", int'(a_done), int'(ma.finished));
        check_val("b_q",    int'(b_q),    mb.q);
        check_val("b_tc",   int'(b_tc),   model_tc(mb, MOD_B, 1'b0, en_i, up_i, load_i));
        check_val("b_zero", int'(b_zero), (mb.q == 0) ? 1 : 0);
        check_val("b_done", int'(b_done), int'(mb.finished));
        last_tc_b = b_tc;
        @(posedge clk1);
        ma = model_step(ma, MOD_A, 1'b1, en_i, up_i, start_i, stop_i, load_i, lv);
        mb = model_step(mb, MOD_B, 1'b0, en_i, up_i, start_i, stop_i, load_i, lv);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic apply_reset();
        reset = 1'b0;
        #2;
        check_val("rst_a_q",    int'(a_q),    RV_A);
        check_val("rst_b_q",    int'(b_q),    RV_B);
        check_val("rst_a_done", int'(a_done), 0);
        check_val("rst_b_done", int'(b_done), 0);
        ma = '{q: RV_A, running: 1'b0, finished: 1'b0};
        mb = '{q: RV_B, running: 1'b0, finished: 1'b0};
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit dir;
        int pulses;

        reset = 1'b1;
        en = 1'b0; up = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; load_val = '0;
        c_en = 1'b0; c_up = 1'b0; c_start = 1'b0; c_stop = 1'b0; c_load = 1'b0;
        c_lv_u = '0; c_lv_t = '0;
        last_tc_b = 1'b0;
        ma = '{q: RV_A, running: 1'b0, finished: 1'b0};
        mb = '{q: RV_B, running: 1'b0, finished: 1'b0};

        @(posedge clk1);
        #1;
        apply_reset();

        // Up count with wrap at 9
        tick(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(1, 1, 0, 0, 0, 0);
        check_val("upwrap_q", int'(a_q), 2);

        // Start and stop together from RUN -> IDLE, no further counting
        tick(0, 1, 1, 1, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        check_val("stop_wins_q", int'(a_q), 2);
        // Load during an enabled RUN cycle saturates and suppresses the step
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 1, 12);
        check_val("load_sat_q", int'(a_q), 9);

        // Timer halt: 3,2,1,0 then hold in DONE
        tick(0, 0, 0, 1, 1, 3);
        tick(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0, 0);
        check_val("halt_q",    int'(a_q),    0);
        check_val("halt_done", int'(a_done), 1);
        check_val("halt_zero", int'(a_zero), 1);
        check_val("halt_tc",   int'(a_tc),   0);
        tick(1, 0, 0, 0, 0, 0);

        // Down wrap on the mod-6 wrapping instance
        tick(0, 0, 1, 0, 1, 0);
        tick(1, 0, 0, 0, 0, 0);
        check_val("dwrap_tc_prior", int'(last_tc_b), 1);
        check_val("dwrap_q",        int'(b_q),       5);
        check_val("dwrap_done",     int'(b_done),    0);

        // Asynchronous reset in the middle of a run at q=7
        tick(0, 1, 1, 0, 1, 7);
        tick(0, 1, 0, 0, 0, 0);
        check_val("prereset_q", int'(a_q), 7);
        apply_reset();
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, 0);
        check_val("postreset_idle_q", int'(a_q), RV_A);
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        check_val("postreset_run_q", int'(a_q), 1);

        // Randomized traffic; direction persists for random stretches so
        // the timer instance reaches its halt from time to time.
        dir = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            tick($urandom_range(0, 9) < 7, dir,
                 $urandom_range(0, 9) < 2,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 15)));
            if ($urandom_range(0, 199) == 0) apply_reset();
        end
        tick(0, 0, 0, 0, 0, 0);

        // Cascade: 59 -> 00, tens tc pulses exactly once
        c_load = 1'b1; c_lv_u = 4'd9; c_lv_t = 4'd5; c_start = 1'b1; c_en = 1'b0; c_up = 1'b1;
        @(posedge clk1);
        #1;
        c_load = 1'b0; c_start = 1'b0; c_en = 1'b1;
        @(negedge clk1);
        check_val("cas_u_pre",    int'(u_q),  9);
        check_val("cas_t_pre",    int'(t_q),  5);
        check_val("cas_u_tc_pre", int'(u_tc), 1);
        check_val("cas_t_tc_pre", int'(t_tc), 1);
        pulses = int'(t_tc);
        @(posedge clk1);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1);
            if (i == 0) begin
                check_val("cas_u_00",  int'(u_q),  0);
                check_val("cas_t_00",  int'(t_q),  0);
                check_val("cas_t_tc0", int'(t_tc), 0);
            end
            pulses += int'(t_tc);
            @(posedge clk1);
            #1;
        end
        check_val("cas_u_10",   int'(u_q), 0);
        check_val("cas_t_10",   int'(t_q), 1);
        check_val("cas_pulses", pulses,    1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
